// File: rtl/player_button_encoder_pkg.sv
// Shared types and helpers for the player button encoder: colour codes, FSM states,
// and one-hot decode helpers.
package player_button_encoder_pkg;

   localparam int NUM_COLORS = 4;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      GREEN  = 2'd1,
      BLUE   = 2'd2,
      YELLOW = 2'd3
   } color_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HELD,
      S_WAIT_REL
   } btn_state_e;

   function automatic logic is_onehot(input logic [NUM_COLORS-1:0] v);
      return (v != '0) && ((v & (v - NUM_COLORS'(1))) == '0);
   endfunction

   // Only meaningful for a one-hot input; callers check is_onehot first.
   function automatic color_e encode_color(input logic [NUM_COLORS-1:0] v);
      color_e c;
      if (v[3])      c = YELLOW;
      else if (v[2]) c = BLUE;
      else if (v[1]) c = GREEN;
      else           c = RED;
      return c;
   endfunction

endpackage

// File: rtl/player_button_encoder_if.sv
// Colour-code handshake between the button encoder (master) and the sequence controller.
interface player_button_encoder_if #(
   parameter int CODE_W = 2
) ();

   logic [CODE_W-1:0] code_out;
   logic              code_valid;
   logic              code_ack;

   modport master (output code_out, output code_valid, input code_ack);
   modport slave  (input code_out, input code_valid, output code_ack);

endinterface

// File: rtl/player_button_encoder_debouncer.sv
// One button: two-flop synchroniser followed by a stable-count debouncer.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic db
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_p0;
   logic          sync_p1;
   logic [CW-1:0] cnt;

   // sync stage -> sync_p1; debounce stage -> db
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         cnt     <= '0;
         db      <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         if (sync_p1 == db) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            db  <= ~db;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/player_button_encoder.sv
// Player-control front end: debounced buttons -> press FSM -> colour code buffer with
// valid/ack handshake, plus multi-press/overrun pulses and LED echo.
module player_button_encoder
   import player_button_encoder_pkg::*;
#(
   parameter int COLOR_CODEFY_W  = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_COLORS-1:0]         btn_raw,
   input  logic                          enable,
   input  logic                          flush,
   player_button_encoder_if.master       code_bus,
   output logic                          multi_press,
   output logic                          overrun,
   output logic [NUM_COLORS-1:0]         led_echo
);

   logic [NUM_COLORS-1:0] db;
   logic [NUM_COLORS-1:0] held;
   logic [NUM_COLORS-1:0] held_nxt;
   btn_state_e            state;
   btn_state_e            state_nxt;
   logic                  emit;
   logic                  multi_nxt;

   for (genvar i = 0; i < NUM_COLORS; i++) begin : g_btn
      button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (btn_raw[i]),
         .db    (db[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         held  <= '0;
      end else begin
         state <= state_nxt;
         held  <= held_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      held_nxt  = held;
      emit      = 1'b0;
      multi_nxt = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (db != '0) begin
               state_nxt = S_WAIT_REL;
               if (!is_onehot(db)) begin
                  multi_nxt = 1'b1;
               end else if (enable) begin
                  emit      = 1'b1;
                  held_nxt  = db;
                  state_nxt = S_HELD;
               end
            end
         end
         S_HELD: begin
            // A second button while holding is flagged once; the earlier press stands.
            if ((db & ~held) != '0) begin
               multi_nxt = 1'b1;
               state_nxt = S_WAIT_REL;
            end else if (db == '0) begin
               state_nxt = S_IDLE;
            end
         end
         S_WAIT_REL: begin
            if (db == '0) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign led_echo = (state == S_HELD) ? held : '0;

   // output buffer: flush beats emit, emit beats ack; a blocked emit is dropped as overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_bus.code_out   <= '0;
         code_bus.code_valid <= 1'b0;
         multi_press         <= 1'b0;
         overrun             <= 1'b0;
      end else begin
         multi_press <= multi_nxt;
         overrun     <= 1'b0;
         if (flush) begin
            code_bus.code_valid <= 1'b0;
         end else if (emit) begin
            if (!code_bus.code_valid || code_bus.code_ack) begin
               code_bus.code_out   <= COLOR_CODEFY_W'(encode_color(db));
               code_bus.code_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (code_bus.code_ack && code_bus.code_valid) begin
            code_bus.code_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_player_button_encoder.sv
// Directed bench for player_button_encoder with DEBOUNCE_CYCLES=4.
module tb_player_button_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn_raw;
   logic       enable;
   logic       flush;
   logic       multi_press;
   logic       overrun;
   logic [3:0] led_echo;

   int errors = 0;
   int checks = 0;
   int multi_cnt = 0;
   int ovr_cnt = 0;
   int m0;
   int o0;

   player_button_encoder_if #(.CODE_W(2)) bus ();

   player_button_encoder #(.COLOR_CODEFY_W(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .enable      (enable),
      .flush       (flush),
      .code_bus    (bus.master),
      .multi_press (multi_press),
      .overrun     (overrun),
      .led_echo    (led_echo)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (multi_press === 1'b1) multi_cnt = multi_cnt + 1;
      if (overrun === 1'b1)     ovr_cnt = ovr_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic ack_once();
      bus.code_ack = 1'b1;
      tick(1);
      bus.code_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      btn_raw = 4'b0000;
      enable = 1'b1;
      flush = 1'b0;
      bus.code_ack = 1'b0;
      tick(2);
      chk("rst_valid", {7'd0, bus.code_valid}, 8'd0);
      chk("rst_code", {6'd0, bus.code_out}, 8'd0);
      chk("rst_led", {4'd0, led_echo}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(3);

      // 1: green press, latency and ack
      btn_raw = 4'b0010;
      tick(6);
      chk("t1_valid_early", {7'd0, bus.code_valid}, 8'd0);
      tick(1);
      chk("t1_valid", {7'd0, bus.code_valid}, 8'd1);
      chk("t1_code", {6'd0, bus.code_out}, 8'd1);
      chk("t1_led", {4'd0, led_echo}, 8'h02);
      tick(3);
      ack_once();
      chk("t1_ack_clr", {7'd0, bus.code_valid}, 8'd0);
      chk("t1_code_hold", {6'd0, bus.code_out}, 8'd1);
      btn_raw = 4'b0000;
      tick(10);
      chk("t1_no_repeat", {7'd0, bus.code_valid}, 8'd0);
      chk("t1_led_off", {4'd0, led_echo}, 8'd0);

      // 2: 3-cycle glitch is rejected, 4-cycle pulse is accepted
      btn_raw = 4'b0001;
      tick(3);
      btn_raw = 4'b0000;
      tick(10);
      chk("t2_glitch", {7'd0, bus.code_valid}, 8'd0);
      btn_raw = 4'b0001;
      tick(4);
      btn_raw = 4'b0000;
      tick(6);
      chk("t2_pulse_valid", {7'd0, bus.code_valid}, 8'd1);
      chk("t2_pulse_code", {6'd0, bus.code_out}, 8'd0);
      ack_once();
      tick(10);

      // 3: simultaneous red+blue is a multi-press, then yellow
      m0 = multi_cnt;
      btn_raw = 4'b0101;
      tick(10);
      chk("t3_multi_cnt", 8'(multi_cnt - m0), 8'd1);
      chk("t3_no_valid", {7'd0, bus.code_valid}, 8'd0);
      btn_raw = 4'b0000;
      tick(10);
      btn_raw = 4'b1000;
      tick(10);
      chk("t3_yel_valid", {7'd0, bus.code_valid}, 8'd1);
      chk("t3_yel_code", {6'd0, bus.code_out}, 8'd3);
      ack_once();
      btn_raw = 4'b0000;
      tick(10);

      // 4: overrun when unacked, then ack coinciding with emit
      btn_raw = 4'b0100;
      tick(10);
      chk("t4_blue_code", {6'd0, bus.code_out}, 8'd2);
      btn_raw = 4'b0000;
      tick(10);
      o0 = ovr_cnt;
      btn_raw = 4'b0001;
      tick(10);
      chk("t4_ovr_cnt", 8'(ovr_cnt - o0), 8'd1);
      chk("t4_ovr_code", {6'd0, bus.code_out}, 8'd2);
      chk("t4_ovr_valid", {7'd0, bus.code_valid}, 8'd1);
      btn_raw = 4'b0000;
      tick(10);
      o0 = ovr_cnt;
      btn_raw = 4'b0001;
      tick(6);
      ack_once();
      chk("t4_swap_code", {6'd0, bus.code_out}, 8'd0);
      chk("t4_swap_valid", {7'd0, bus.code_valid}, 8'd1);
      tick(3);
      chk("t4_swap_no_ovr", 8'(ovr_cnt - o0), 8'd0);
      ack_once();
      btn_raw = 4'b0000;
      tick(10);

      // 5: press while disabled needs a release before it counts
      enable = 1'b0;
      btn_raw = 4'b0010;
      tick(10);
      chk("t5_dis_valid", {7'd0, bus.code_valid}, 8'd0);
      enable = 1'b1;
      tick(5);
      chk("t5_en_held", {7'd0, bus.code_valid}, 8'd0);
      btn_raw = 4'b0000;
      tick(10);
      btn_raw = 4'b0010;
      tick(10);
      chk("t5_repress_valid", {7'd0, bus.code_valid}, 8'd1);
      chk("t5_repress_code", {6'd0, bus.code_out}, 8'd1);
      ack_once();
      btn_raw = 4'b0000;
      tick(10);

      // 6: asynchronous reset mid-press, re-debounce, flush
      btn_raw = 4'b1000;
      tick(10);
      chk("t6_pre_code", {6'd0, bus.code_out}, 8'd3);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", {7'd0, bus.code_valid}, 8'd0);
      chk("t6_rst_code", {6'd0, bus.code_out}, 8'd0);
      chk("t6_rst_led", {4'd0, led_echo}, 8'd0);
      tick(2);
      @(negedge clk);
      rst_n = 1'b1;
      tick(5);
      chk("t6_post_early", {7'd0, bus.code_valid}, 8'd0);
      tick(2);
      chk("t6_post_valid", {7'd0, bus.code_valid}, 8'd1);
      chk("t6_post_code", {6'd0, bus.code_out}, 8'd3);
      chk("t6_post_led", {4'd0, led_echo}, 8'h08);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      chk("t6_flush", {7'd0, bus.code_valid}, 8'd0);
      ack_once();
      chk("t6_idle_ack", {7'd0, bus.code_valid}, 8'd0);
      chk("t6_idle_ack_code", {6'd0, bus.code_out}, 8'd3);
      btn_raw = 4'b0000;
      tick(10);

      // flush on the emit cycle discards the press without overrun
      o0 = ovr_cnt;
      btn_raw = 4'b0010;
      tick(6);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(2);
      chk("t6_flush_emit", {7'd0, bus.code_valid}, 8'd0);
      chk("t6_flush_no_ovr", 8'(ovr_cnt - o0), 8'd0);
      btn_raw = 4'b0000;
      tick(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
